iterative_tea_encryptor: RTL and testbench
==========================================

# iterative_tea_encryptor

Iterative TEA encryptor: accepts one 64-bit plaintext block and a 128-bit key over a valid/ready handshake, then runs one TEA encryption round per enabled clock. After the last round it presents the 64-bit ciphertext over a second valid/ready handshake. It is the transmit-side counterpart to the pipelined TEA decryptor: it uses the same block/key word layout and the same DELTA, and trades throughput for roughly 1/32 of the round-logic area.

## Interface
- ROUNDS, 32: number of TEA rounds. Legal range 1..63; the decryptor requires 32.
- DELTA, 32'h9E37_79B9: TEA key-schedule constant.

- clk  in  1  clock. All state is updated on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  clock enable; when 0, all state is frozen.
- in_valid  in  1  plaintext/key present.
- in_ready  out  1  block can accept.
- inBlock64  in  64  plaintext, V0 = [31:0], V1 = [63:32].
- key  in  128  k0 = [31:0], k1 = [63:32], k2 = [95:64], k3 = [127:96].
- out_valid  out  1  ciphertext present.
- out_ready  in  1  consumer can take ciphertext.
- outBlock64  out  64  ciphertext {V1, V0}.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Registers: v0, v1 (32 bits each), k (128 bits), sum (32 bits), cnt (6 bits).
- Handshake gating: a handshake completes only on a rising edge where ena = 1.
- in_ready = ena & (state == IDLE) & ~rst. It is combinational.
- IDLE:
  - On an accept (in_valid & in_ready), latch v0/v1 from inBlock64 and k from key.
  - Clear sum and cnt, then go to RUN.
  - Later changes on key or inBlock64 have no effect until the next accept.
- RUN, each edge with ena = 1, performed in this order:
  - sum' = sum + DELTA
  - v0' = v0 + (((v1<<4)+k0) ^ (v1+sum') ^ ((v1>>5)+k1))
  - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+sum') ^ ((v0'>>5)+k3))
  - cnt' = cnt + 1
- Arithmetic rules:
  - All arithmetic is 32-bit, modulo 2^32.
  - Shifts are logical; >>5 shifts in zeros.
- RUN exit: the round taken with cnt == ROUNDS-1 is the last one. On that edge the FSM goes to DONE and outBlock64 is loaded with {v1', v0'}.
- DONE:
  - out_valid = 1; outBlock64 is held stable.
  - On out_valid & out_ready & ena, go to IDLE; out_valid falls on that edge.
- Outputs:
  - out_valid is registered.
  - outBlock64 is registered; it keeps the last ciphertext until it is overwritten or reset.
- Boundary conditions:
  - in_valid while in RUN or DONE: ignored, since in_ready = 0.
  - ena = 0 in RUN: the round is stalled; cnt and sum hold.
  - ena = 0 in DONE: out_valid is held and no transfer occurs.
  - rst in any state: FSM returns to IDLE and any in-flight block is discarded.
  - Final sum after ROUNDS rounds = DELTA*ROUNDS mod 2^32 (0xC6EF3720 for 32 rounds).

## Timing
- Reset values: out_valid = 0, outBlock64 = 0, v0 = v1 = sum = 0, cnt = 0, k = 0. in_ready is 0 during rst and 1 on the first ena cycle after.
- Latency: accept at edge N → out_valid high after edge N+ROUNDS (32 cycles with ena held high).
- Throughput with out_ready held high: one block per ROUNDS+2 cycles (accept, ROUNDS rounds, DONE, IDLE); 34 cycles for ROUNDS = 32.
- Combinational depth: one full TEA round (two 32-bit adds into XOR, then an add, for each of V0 and V1).

## Configuration
- TEA_ENC_BACK2BACK_EN defined:
  - In DONE, in_ready = ena & out_ready & ~rst.
  - A simultaneous output transfer and input accept goes directly DONE → RUN and loads the new block.
  - Period becomes ROUNDS+1 cycles (33 for ROUNDS = 32).
- TEA_ENC_BACK2BACK_EN undefined:
  - in_ready is asserted only in IDLE.
  - Period is ROUNDS+2 cycles.

## Test plan
- Zero vector: key = 0, inBlock64 = 0, out_ready = 1 → out_valid 32 cycles after accept, outBlock64 = 64'h94BAA940_41EA3A0A.
- Round-trip: random keys and blocks encrypted here, then decrypted by the software TEA model → original plaintext every time. Also check sum = 0xC6EF3720 at DONE.
- Backpressure: out_ready = 0 for 10 cycles in DONE → out_valid and outBlock64 held, in_ready = 0, in_valid pulses ignored. Then out_ready = 1 → single transfer.
- ena stall: drop ena for 5 cycles mid-RUN → latency extended by exactly 5 cycles, ciphertext unchanged.
- Reset mid-RUN: rst at round 17 → out_valid = 0, outBlock64 = 0, in_ready = 1 next ena cycle. The next block encrypts correctly.
- Back-to-back streaming of 4 blocks with in_valid and out_ready held high → input period of 34 cycles without TEA_ENC_BACK2BACK_EN and 33 cycles with it, all four ciphertexts correct.

Source files
------------

// File: rtl/iterative_tea_encryptor.sv
// Iterative TEA encryptor: one round per enabled clock, valid/ready on both sides.
// Optional build macro TEA_ENC_BACK2BACK_EN lets DONE hand straight over to a new block.
module iterative_tea_encryptor #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E37_79B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_d;
  logic [31:0]        v0;
  logic [31:0]        v1;
  logic [31:0]        sum;
  logic [127:0]       k;
  logic [CNT_W-1:0]   cnt;

  logic [31:0]        sum_nxt;
  logic [31:0]        v0_nxt;
  logic [31:0]        v1_nxt;
  logic               last_round;
  logic               accept;
  logic               out_xfer;

  // One TEA round; v1 update uses the freshly computed v0.
  always_comb begin
    sum_nxt = sum + DELTA;
    v0_nxt  = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + sum_nxt) ^ ((v1 >> 5) + k[63:32]));
    v1_nxt  = v1 + (((v0_nxt << 4) + k[95:64]) ^ (v0_nxt + sum_nxt) ^ ((v0_nxt >> 5) + k[127:96]));
  end

  assign last_round = (cnt == CNT_W'(ROUNDS - 1));
  assign out_xfer   = out_valid & out_ready & ena;

`ifdef TEA_ENC_BACK2BACK_EN
  assign in_ready = ena & ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
`else
  assign in_ready = ena & ~rst & (state == IDLE);
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (ena && last_round) state_d = DONE;
      DONE:    if (out_xfer) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0         <= '0;
      v1         <= '0;
      sum        <= '0;
      k          <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      outBlock64 <= '0;
    end else if (ena) begin
      out_valid <= (state_d == DONE);
      if (accept) begin
        v0  <= inBlock64[31:0];
        v1  <= inBlock64[63:32];
        k   <= key;
        sum <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        v0  <= v0_nxt;
        v1  <= v1_nxt;
        sum <= sum_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last_round) outBlock64 <= {v1_nxt, v0_nxt};
      end
    end
  end

endmodule

// File: tb/tb_iterative_tea_encryptor.sv
// Self-checking bench for iterative_tea_encryptor against a software TEA model.
module tb_iterative_tea_encryptor;

  localparam int unsigned ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E37_79B9;
`ifdef TEA_ENC_BACK2BACK_EN
  localparam int PERIOD = ROUNDS + 1;
`else
  localparam int PERIOD = ROUNDS + 2;
`endif
  localparam int NVEC = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  inBlock64;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  outBlock64;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] out_q[$];

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  ct;
  } vec_t;

  vec_t vecs[NVEC];

  iterative_tea_encryptor #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inBlock64  (inBlock64),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outBlock64 (outBlock64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output transfers, sampled on the falling edge before the capturing rising edge.
  always @(negedge clk) begin
    if (!rst && ena && out_valid && out_ready) out_q.push_back(outBlock64);
  end

  function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] kk);
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;
    y = pt[31:0];
    z = pt[63:32];
    s = 32'h0;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      s = s + DELTA;
      y = y + (((z << 4) + kk[31:0]) ^ (z + s) ^ ((z >> 5) + kk[63:32]));
      z = z + (((y << 4) + kk[95:64]) ^ (y + s) ^ ((y >> 5) + kk[127:96]));
    end
    return {z, y};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] ct, input logic [127:0] kk);
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;
    y = ct[31:0];
    z = ct[63:32];
    s = 32'(DELTA * ROUNDS);
    for (int i = 0; i < int'(ROUNDS); i++) begin
      z = z - (((y << 4) + kk[95:64]) ^ (y + s) ^ ((y >> 5) + kk[127:96]));
      y = y - (((z << 4) + kk[31:0]) ^ (z + s) ^ ((z >> 5) + kk[63:32]));
      s = s - DELTA;
    end
    return {z, y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic send(input logic [127:0] k_in, input logic [63:0] pt_in, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    key       = k_in;
    inBlock64 = pt_in;
    in_valid  = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout_fail("send");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [63:0] ct, output int vcyc, output logic [31:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout_fail("recv");
    vcyc = cyc;
    ct   = outBlock64;
    s    = dut.sum;
  endtask

  initial begin
    int          acc;
    int          vcyc;
    logic [63:0] ct;
    logic [31:0] s;
    int          acc_q[$];
    int          n;

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inBlock64 = '0; key = '0;

    vecs[0] = '{key: 128'h0, pt: 64'h0, ct: 64'h94BAA940_41EA3A0A};
    for (int i = 1; i < NVEC; i++) begin
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt  = {$urandom, $urandom};
      vecs[i].ct  = tea_enc(vecs[i].pt, vecs[i].key);
    end
    vecs[NVEC-1].key = {128{1'b1}};
    vecs[NVEC-1].ct  = tea_enc(vecs[NVEC-1].pt, vecs[NVEC-1].key);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_outblock", outBlock64, 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);

    // Table vectors with latency, sum and round-trip checks.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i].key, vecs[i].pt, acc);
      recv(ct, vcyc, s);
      check($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
      check($sformatf("vec%0d_latency", i), 64'(vcyc - acc), 64'(ROUNDS));
      check($sformatf("vec%0d_sum", i), 64'(s), 64'(32'(DELTA * ROUNDS)));
      check($sformatf("vec%0d_roundtrip", i), tea_dec(ct, vecs[i].key), vecs[i].pt);
    end
    check("zero_sum_const", 64'(s) & 64'h0, 64'h0);
    checks--;

    // Backpressure in DONE with ignored input pulses.
    @(negedge clk);
    out_ready = 1'b0;
    send(vecs[1].key, vecs[1].pt, acc);
    recv(ct, vcyc, s);
    out_q.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      inBlock64 = {$urandom, $urandom};
      #1;
      check("bp_out_valid", 64'(out_valid), 64'h1);
      check("bp_outblock", outBlock64, vecs[1].ct);
      check("bp_in_ready", 64'(in_ready), 64'h0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_fall", 64'(out_valid), 64'h0);
    repeat (3) @(negedge clk);
    check("bp_single_xfer", 64'(out_q.size()), 64'h1);
    if (out_q.size() > 0) check("bp_xfer_data", out_q[0], vecs[1].ct);

    // Enable stall mid-RUN.
    send(vecs[2].key, vecs[2].pt, acc);
    repeat (10) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    recv(ct, vcyc, s);
    check("stall_ct", ct, vecs[2].ct);
    check("stall_latency", 64'(vcyc - acc), 64'(ROUNDS + 5));

    // Reset in the middle of a block.
    send(vecs[3].key, vecs[3].pt, acc);
    repeat (17) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", 64'(in_ready), 64'h0);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_outblock", outBlock64, 64'h0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'h1);
    send(vecs[4].key, vecs[4].pt, acc);
    recv(ct, vcyc, s);
    check("midrst_next_ct", ct, vecs[4].ct);

    // Streaming with in_valid and out_ready held high.
    @(negedge clk);
    @(negedge clk);
    out_q.delete();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      key       = vecs[b+1].key;
      inBlock64 = vecs[b+1].pt;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        timeout_fail("stream_accept");
        break;
      end
      acc_q.push_back(cyc + 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_q.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("stream_count", 64'(out_q.size()), 64'h4);
    for (int b = 0; b < 4 && b < out_q.size(); b++)
      check($sformatf("stream%0d_ct", b), out_q[b], vecs[b+1].ct);
    for (int b = 1; b < acc_q.size(); b++)
      check($sformatf("stream%0d_period", b), 64'(acc_q[b] - acc_q[b-1]), 64'(PERIOD));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
